// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: control-word layout, load/store widths,
// exception codes and the LSU state encoding.
package mem_stage_pkg;

  localparam int CW_W        = 14;
  localparam int CW_BT       = 13;
  localparam int CW_RF_WB    = 12;
  localparam int CW_MEM_WE   = 11;
  localparam int CW_WB_SRC   = 9;
  localparam int CW_PC_SRC   = 8;
  localparam int CW_RD       = 3;
  localparam int CW_F3       = 0;

  localparam logic [1:0] WB_MEM = 2'b01;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_REQ    = 2'b01;
  localparam logic [1:0] ST_WAIT_R = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: store steering/strobes and legality checks on the
// request side, byte/half extraction and extension on the response side.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  req_off,
  input  logic [2:0]  req_funct3,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [31:0] req_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic        misaligned,
  output logic        illegal_width,
  input  logic [1:0]  rsp_off,
  input  logic [2:0]  rsp_funct3,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] rsp_shift;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  always_comb begin
    st_wdata = req_data;
    st_wstrb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_data[7:0]}};
        st_wstrb = 4'b0001 << req_off;
      end
      2'b01: begin
        st_wdata = {2{req_data[15:0]}};
        st_wstrb = req_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Width legality takes precedence so an illegal encoding never reports misalignment.
  always_comb begin
    illegal_width = 1'b0;
    if (req_is_store)
      illegal_width = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else if (req_is_load)
      illegal_width = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    misaligned = ~illegal_width & (req_is_load | req_is_store) &
                 (((req_funct3[1:0] == 2'b01) & req_off[0]) |
                  ((req_funct3[1:0] == 2'b10) & (req_off != 2'b00)));
  end

  always_comb begin
    rsp_shift = rsp_rdata >> {rsp_off, 3'b000};
    rsp_byte  = rsp_shift[7:0];
    rsp_half  = rsp_off[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    case (rsp_funct3)
      F3_B:    ld_data = {{24{rsp_byte[7]}}, rsp_byte};
      F3_H:    ld_data = {{16{rsp_half[15]}}, rsp_half};
      F3_BU:   ld_data = {24'b0, rsp_byte};
      F3_HU:   ld_data = {16'b0, rsp_half};
      default: ld_data = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Registered MEM stage: accepts one EX instruction at a time, runs a req/gnt/rvalid
// memory access when needed and presents one out_valid pulse per instruction to WB.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              stall_mem,
  input  logic [ADDR_W-1:0] calculated_adr,
  input  logic [31:0]       pc_plus_4_ex,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       regfileb_ex,
  input  logic [13:0]       control_word_ex,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       mem_data_out,
  output logic [ADDR_W-1:0] target_pc,
  output logic [31:0]       pc_plus_4_mem,
  output logic [31:0]       alu_result_mem,
  output logic [4:0]        rd_mem,
  output logic [3:0]        control_word_mem,
  output logic              exc_valid,
  output logic [1:0]        exc_code
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] target_pc_q, target_pc_d;
  logic [31:0]       pc4_q, pc4_d;
  logic [31:0]       alu_q, alu_d;
  logic [4:0]        rd_q, rd_d;
  logic              rf_wb_q, rf_wb_d;
  logic [1:0]        wb_src_q, wb_src_d;
  logic              br_pc_q, br_pc_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [1:0]        exc_q, exc_d;

  logic        ex_is_store, ex_is_load, ex_is_mem;
  logic [2:0]  ex_funct3;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic        misaligned, illegal_width, timeout_hit;

  assign ex_funct3   = control_word_ex[CW_F3 +: 3];
  assign ex_is_store = control_word_ex[CW_MEM_WE];
  assign ex_is_load  = ~ex_is_store & (control_word_ex[CW_WB_SRC +: 2] == WB_MEM);
  assign ex_is_mem   = ex_is_store | ex_is_load;
  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT - 1));

  lsu_align u_align (
    .req_off       (calculated_adr[1:0]),
    .req_funct3    (ex_funct3),
    .req_is_load   (ex_is_load),
    .req_is_store  (ex_is_store),
    .req_data      (regfileb_ex),
    .st_wdata      (st_wdata),
    .st_wstrb      (st_wstrb),
    .misaligned    (misaligned),
    .illegal_width (illegal_width),
    .rsp_off       (target_pc_q[1:0]),
    .rsp_funct3    (funct3_q),
    .rsp_rdata     (mem_rdata),
    .ld_data       (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_pc_d = target_pc_q;
    pc4_d       = pc4_q;
    alu_d       = alu_q;
    rd_d        = rd_q;
    rf_wb_d     = rf_wb_q;
    wb_src_d    = wb_src_q;
    br_pc_d     = br_pc_q;
    funct3_d    = funct3_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_data_d  = mem_data_q;
    exc_d       = exc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          target_pc_d = calculated_adr;
          pc4_d       = pc_plus_4_ex;
          alu_d       = ALU_result;
          rd_d        = control_word_ex[CW_RD +: 5];
          rf_wb_d     = control_word_ex[CW_RF_WB];
          wb_src_d    = control_word_ex[CW_WB_SRC +: 2];
          br_pc_d     = control_word_ex[CW_BT] & control_word_ex[CW_PC_SRC];
          funct3_d    = ex_funct3;
          mem_data_d  = 32'b0;
          cnt_d       = '0;
          exc_d       = illegal_width ? EXC_ILLEGAL : (misaligned ? EXC_MISALIGN : EXC_NONE);
          // Request fields freeze here so they stay stable for the whole REQ phase.
          mem_addr_d  = {calculated_adr[ADDR_W-1:2], 2'b00};
          mem_we_d    = ex_is_store & ~illegal_width & ~misaligned;
          mem_wdata_d = st_wdata;
          mem_wstrb_d = ex_is_store ? st_wstrb : 4'b0000;
          state_d     = (ex_is_mem & ~illegal_width & ~misaligned) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          if (mem_we_q) begin
            state_d = ST_DONE;
          end else if (mem_rvalid) begin
            mem_data_d = ld_data;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else if (timeout_hit) begin
          exc_d   = EXC_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          mem_data_d = ld_data;
          state_d    = ST_DONE;
        end else if (timeout_hit) begin
          exc_d   = EXC_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      target_pc_q <= '0;
      pc4_q       <= '0;
      alu_q       <= '0;
      rd_q        <= '0;
      rf_wb_q     <= 1'b0;
      wb_src_q    <= '0;
      br_pc_q     <= 1'b0;
      funct3_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_data_q  <= '0;
      exc_q       <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_pc_q <= target_pc_d;
      pc4_q       <= pc4_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      rf_wb_q     <= rf_wb_d;
      wb_src_q    <= wb_src_d;
      br_pc_q     <= br_pc_d;
      funct3_q    <= funct3_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_data_q  <= mem_data_d;
      exc_q       <= exc_d;
    end
  end

  assign in_ready         = (state_q == ST_IDLE);
  assign stall_mem        = ~in_ready;
  assign mem_req          = (state_q == ST_REQ);
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_wstrb        = mem_wstrb_q;
  assign out_valid        = (state_q == ST_DONE);
  assign mem_data_out     = mem_data_q;
  assign target_pc        = target_pc_q;
  assign pc_plus_4_mem    = pc4_q;
  assign alu_result_mem   = alu_q;
  assign rd_mem           = rd_q;
  assign control_word_mem = {rf_wb_q & (exc_q == EXC_NONE), wb_src_q, br_pc_q};
  assign exc_valid        = out_valid & (exc_q != EXC_NONE);
  assign exc_code         = exc_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized and directed checks of mem_stage_lsu against a behavioural model
// that derives lanes, extension, exceptions and latency from the access rules.
module tb_mem_stage_lsu;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready, stall_mem;
  logic [ADDR_W-1:0] calculated_adr;
  logic [31:0]       pc_plus_4_ex, ALU_result, regfileb_ex;
  logic [13:0]       control_word_ex;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic [31:0]       mem_data_out;
  logic [ADDR_W-1:0] target_pc;
  logic [31:0]       pc_plus_4_mem, alu_result_mem;
  logic [4:0]        rd_mem;
  logic [3:0]        control_word_mem;
  logic              exc_valid;
  logic [1:0]        exc_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stall_mem(stall_mem),
    .calculated_adr(calculated_adr), .pc_plus_4_ex(pc_plus_4_ex), .ALU_result(ALU_result),
    .regfileb_ex(regfileb_ex), .control_word_ex(control_word_ex),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .mem_data_out(mem_data_out), .target_pc(target_pc),
    .pc_plus_4_mem(pc_plus_4_mem), .alu_result_mem(alu_result_mem), .rd_mem(rd_mem),
    .control_word_mem(control_word_mem), .exc_valid(exc_valid), .exc_code(exc_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One instruction through the stage, with the bench acting as data memory.
  // gnt_dly: request cycles without gnt before the granting one; rv_dly: cycles from gnt to rvalid.
  task automatic do_op(input bit bt, input bit rf_wb, input bit we, input logic [1:0] wb_src,
                       input bit pc_src, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] adr, input logic [31:0] rs2, input logic [31:0] rdata,
                       input int gnt_dly, input int rv_dly);
    bit is_st, is_ld, ill, mis, granted, done, tmo;
    int off, k, exp_lat, exp_reqs, lat, reqs, waited;
    logic [1:0]  exp_exc;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata, exp_ld, pc4, alu;
    logic [7:0]  b;
    logic [15:0] h;

    is_st = we;
    is_ld = !we && (wb_src == 2'b01);
    off   = adr % 4;
    ill   = 0;
    if (is_st) ill = (f3 > 3'd2);
    else if (is_ld) ill = (f3 == 3'd3) || (f3 >= 3'd6);
    mis = !ill && (is_st || is_ld) &&
          ((f3 % 4 == 1 && off % 2 != 0) || (f3 % 4 == 2 && off != 0));
    exp_exc = ill ? 2'd2 : (mis ? 2'd1 : 2'd0);

    exp_strb  = 4'hF;
    exp_wdata = rs2;
    if (f3 % 4 == 0) begin exp_strb = 4'(1 << off); exp_wdata = {24'b0, rs2[7:0]} * 32'h0101_0101; end
    if (f3 % 4 == 1) begin exp_strb = (off >= 2) ? 4'hC : 4'h3; exp_wdata = {16'b0, rs2[15:0]} * 32'h0001_0001; end

    b = 8'(rdata >> (8 * off));
    h = 16'(rdata >> (16 * (off / 2)));
    case (f3)
      3'd0:    exp_ld = 32'($signed(b));
      3'd1:    exp_ld = 32'($signed(h));
      3'd4:    exp_ld = {24'b0, b};
      3'd5:    exp_ld = {16'b0, h};
      default: exp_ld = rdata;
    endcase

    tmo = 0;
    if (exp_exc != 0 || !(is_st || is_ld)) begin
      exp_lat = 1; exp_reqs = 0;
    end else begin
      k = gnt_dly + 1 + (is_ld ? rv_dly : 0);
      if (gnt_dly + 1 > TIMEOUT) begin tmo = 1; exp_reqs = TIMEOUT; end
      else begin exp_reqs = gnt_dly + 1; tmo = (k > TIMEOUT); end
      exp_lat = tmo ? TIMEOUT + 1 : k + 1;
      if (tmo) exp_exc = 2'd3;
    end
    if (exp_exc != 0 || !is_ld) exp_ld = 32'b0;

    pc4 = $urandom;
    alu = $urandom;
    @(negedge clk);
    check("in_ready_before", {31'b0, in_ready}, 32'd1);
    in_valid        = 1'b1;
    calculated_adr  = adr;
    pc_plus_4_ex    = pc4;
    ALU_result      = alu;
    regfileb_ex     = rs2;
    control_word_ex = {bt, rf_wb, we, wb_src, pc_src, rd, f3};
    @(negedge clk);
    in_valid        = 1'b0;
    calculated_adr  = $urandom;
    regfileb_ex     = $urandom;
    control_word_ex = 14'($urandom);

    lat = 0; reqs = 0; waited = 0; granted = 0; done = 0;
    for (int c = 1; c <= TIMEOUT + 20 && !done; c++) begin
      if (c > 1) @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (out_valid) begin
        lat  = c;
        done = 1;
      end else begin
        check("stall_mem", {31'b0, stall_mem}, 32'd1);
        if (mem_req) begin
          reqs++;
          check("mem_addr", mem_addr, {adr[31:2], 2'b00});
          check("mem_we", {31'b0, mem_we}, {31'b0, is_st});
          check("mem_wstrb", {28'b0, mem_wstrb}, is_st ? {28'b0, exp_strb} : 32'd0);
          if (is_st) check("mem_wdata", mem_wdata, exp_wdata);
          if (reqs > gnt_dly) begin
            mem_gnt = 1'b1;
            granted = 1;
            if (is_ld && rv_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
          end else if ($urandom_range(0, 1) == 1) begin
            mem_rvalid = 1'b1;
          end
        end else if (granted && is_ld) begin
          waited++;
          if (waited == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        end
      end
    end
    if (!done) check("out_valid_bound", 32'd0, 32'd1);
    check("latency", lat, exp_lat);
    check("req_cycles", reqs, exp_reqs);
    check("mem_data_out", mem_data_out, exp_ld);
    check("exc_valid", {31'b0, exc_valid}, {31'b0, exp_exc != 0});
    check("exc_code", {30'b0, exc_code}, {30'b0, exp_exc});
    check("cw_mem", {28'b0, control_word_mem}, {28'b0, rf_wb && exp_exc == 0, wb_src, bt && pc_src});
    check("rd_mem", {27'b0, rd_mem}, {27'b0, rd});
    check("target_pc", target_pc, adr);
    check("pc4_mem", pc_plus_4_mem, pc4);
    check("alu_mem", alu_result_mem, alu);
    @(negedge clk);
    check("out_valid_pulse", {31'b0, out_valid}, 32'd0);
    check("in_ready_after", {31'b0, in_ready}, 32'd1);
  endtask

  logic [2:0]  r_f3;
  logic [1:0]  r_wbs;
  logic [31:0] r_adr;
  int          r_kind;
  logic [2:0]  legal_f3 [5];

  initial begin
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    rst = 1'b1; in_valid = 1'b0; calculated_adr = '0; pc_plus_4_ex = '0; ALU_result = '0;
    regfileb_ex = '0; control_word_ex = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cw_mem", {28'b0, control_word_mem}, 32'd0);

    // SB to byte 3, immediate gnt
    do_op(0, 0, 1, 2'b00, 0, 5'd0, 3'd0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0);
    check("sb_wstrb_lit", {28'b0, mem_wstrb}, 32'h8);
    check("sb_wdata_lit", mem_wdata, 32'hA5A5_A5A5);
    // LB / LBU with gnt and rvalid together
    do_op(0, 1, 0, 2'b01, 0, 5'd7, 3'd0, 32'h2002, 32'h0, 32'h0080_0000, 0, 0);
    check("lb_lit", mem_data_out, 32'hFFFF_FF80);
    do_op(0, 1, 0, 2'b01, 0, 5'd7, 3'd4, 32'h2002, 32'h0, 32'h0080_0000, 0, 0);
    check("lbu_lit", mem_data_out, 32'h0000_0080);
    // Misaligned LW: no bus request, rf_wb suppressed
    do_op(0, 1, 0, 2'b01, 1, 5'd9, 3'd2, 32'h2006, 32'h0, 32'h1234_5678, 0, 0);
    check("lw_mis_cw3", {31'b0, control_word_mem[3]}, 32'd0);
    // LH with slow gnt and slow rvalid
    do_op(1, 1, 0, 2'b01, 1, 5'd3, 3'd1, 32'h3002, 32'h0, 32'hBEEF_1234, 3, 5);
    check("lh_lit", mem_data_out, 32'hFFFF_BEEF);
    // Illegal widths
    do_op(0, 1, 1, 2'b00, 0, 5'd1, 3'd4, 32'h4000, 32'h55, 32'h0, 0, 0);
    do_op(0, 1, 0, 2'b01, 0, 5'd1, 3'd7, 32'h4000, 32'h0, 32'h0, 0, 0);
    // gnt never: timeout in REQ, then a stray rvalid must be ignored
    do_op(0, 1, 0, 2'b01, 0, 5'd2, 3'd2, 32'h5000, 32'h0, 32'hCAFE_F00D, TIMEOUT + 5, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("stray_rv_out_valid", {31'b0, out_valid}, 32'd0);
    check("stray_rv_in_ready", {31'b0, in_ready}, 32'd1);
    // Timeout while waiting for rvalid
    do_op(0, 1, 0, 2'b01, 0, 5'd2, 3'd2, 32'h5004, 32'h0, 32'h1, 2, TIMEOUT);

    // Reset in WAIT_R
    @(negedge clk);
    in_valid = 1'b1; calculated_adr = 32'h6000; control_word_ex = {1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd4, 3'd2};
    pc_plus_4_ex = 32'h44; ALU_result = 32'h55;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_test_req", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rst_test_wait", {31'b0, stall_mem}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    check("midrst_outs", {mem_we, mem_wstrb, out_valid, exc_valid, exc_code, control_word_mem, rd_mem}, 32'd0);
    check("midrst_data", mem_data_out | target_pc | pc_plus_4_mem | alu_result_mem | mem_addr | mem_wdata, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("midrst_stray_rv", {31'b0, out_valid}, 32'd0);
    do_op(0, 1, 0, 2'b01, 0, 5'd4, 3'd2, 32'h6000, 32'h0, 32'h7777_8888, 1, 2);

    for (int i = 0; i < 80; i++) begin
      r_kind = $urandom_range(0, 2);
      r_f3   = 3'($urandom);
      if ($urandom_range(0, 3) != 0) r_f3 = legal_f3[$urandom_range(0, 4)];
      r_adr  = 32'h8000_0000 | $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) r_adr = r_adr & ~32'h3;
      r_wbs  = 2'($urandom_range(0, 2));
      if (r_wbs == 2'b01) r_wbs = 2'b11;
      case (r_kind)
        0: do_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, r_wbs,
                 $urandom_range(0, 1) == 1, 5'($urandom), r_f3, r_adr, $urandom, $urandom, 0, 0);
        1: do_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 2'b01,
                 $urandom_range(0, 1) == 1, 5'($urandom), r_f3, r_adr, $urandom, $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 3));
        default: do_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, 2'($urandom),
                       $urandom_range(0, 1) == 1, 5'($urandom), r_f3, r_adr, $urandom, $urandom,
                       $urandom_range(0, 4), 0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
